prog_sequencer: RTL and testbench

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/seq_pkg.sv | 38 +++
 rtl/seq_watchdog.sv | 29 ++
 rtl/prog_sequencer.sv | 118 +++++++++++
 tb/tb_prog_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state enum, program entry table and strobe encodings for prog_sequencer
package seq_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_RUN    = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_t;

   // Entry address of each program in the series
   localparam int          ENTRY_COUNT  = 3;
   localparam logic [10:0] ENTRY_PROG0  = 11'h000;
   localparam logic [10:0] ENTRY_PROG1  = 11'h100;
   localparam logic [10:0] ENTRY_PROG2  = 11'h200;

   // Start/Done strobe encodings
   localparam logic START_ON  = 1'b1;
   localparam logic START_OFF = 1'b0;
   localparam logic DONE_ON   = 1'b1;
   localparam logic DONE_OFF  = 1'b0;

   // Any index outside the populated part of the series falls back to program 0
   function automatic logic [10:0] entry_lookup(input logic [1:0] idx, input int num_progs);
      logic [10:0] addr;
      case (idx)
         2'd1:    addr = ENTRY_PROG1;
         2'd2:    addr = ENTRY_PROG2;
         default: addr = ENTRY_PROG0;
      endcase
      if (int'(idx) >= num_progs || int'(idx) >= ENTRY_COUNT) begin
         addr = ENTRY_PROG0;
      end
      return addr;
   endfunction

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - RUN-state cycle counter flagging expiry at WDOG_CYCLES-1
module seq_watchdog #(
   parameter int WDOG_CYCLES = 4096
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

   logic [CW-1:0] r_count;
   logic          w_at_limit;

   assign w_at_limit = (r_count == CW'(WDOG_CYCLES - 1));
   assign o_expired  = i_enable && w_at_limit;

   // Count enabled cycles from 0; hold at the limit, restart whenever cleared
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_at_limit) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program series sequencer (IDLE/LAUNCH/RUN/DONE); optional watchdog via SEQ_WATCHDOG_EN
module prog_sequencer
   import seq_pkg::*;
#(
   parameter int NUM_PROGS    = 3,
   parameter int START_CYCLES = 2,
   parameter int WDOG_CYCLES  = 4096
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_halt,
   input  logic [10:0] i_prog_ctr,
   output logic        o_start,
   output logic [10:0] o_entry_addr,
   output logic [1:0]  o_prog_idx,
   output logic        o_done,
   output logic        o_err,
   output logic [10:0] o_last_pc
);

   seq_state_t  r_state, w_next_state;
   logic [3:0]  r_launch_cnt, w_launch_cnt;
   logic [1:0]  r_prog_idx, w_prog_idx;
   logic [10:0] r_last_pc, w_last_pc;
   logic        r_start, w_start;
   logic        r_done, w_done;
   logic        r_err, w_err;
   logic        w_timeout;

`ifdef SEQ_WATCHDOG_EN
   seq_watchdog #(
      .WDOG_CYCLES (WDOG_CYCLES)
   ) u_watchdog (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (r_state != ST_RUN),
      .i_enable  (r_state == ST_RUN),
      .o_expired (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   // State and registered outputs; reset overrides everything
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_launch_cnt <= 4'd0;
         r_prog_idx   <= 2'd0;
         r_last_pc    <= 11'd0;
         r_start      <= START_ON;
         r_done       <= DONE_OFF;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_launch_cnt <= w_launch_cnt;
         r_prog_idx   <= w_prog_idx;
         r_last_pc    <= w_last_pc;
         r_start      <= w_start;
         r_done       <= w_done;
         r_err        <= w_err;
      end
   end

   // Next state and next values of the registered outputs
   always_comb begin
      w_next_state = r_state;
      w_launch_cnt = r_launch_cnt;
      w_prog_idx   = r_prog_idx;
      w_last_pc    = r_last_pc;
      w_err        = r_err;
      case (r_state)
         ST_IDLE: begin
            if (i_req) begin
               w_next_state = ST_LAUNCH;
               w_launch_cnt = 4'(START_CYCLES - 1);
            end
         end
         ST_LAUNCH: begin
            if (r_launch_cnt == 4'd0) begin
               w_next_state = ST_RUN;
            end else begin
               w_launch_cnt = r_launch_cnt - 4'd1;
            end
         end
         ST_RUN: begin
            // Halt beats a simultaneous timeout
            if (i_halt) begin
               w_next_state = ST_DONE;
               w_err        = 1'b0;
               w_last_pc    = i_prog_ctr;
            end else if (w_timeout) begin
               w_next_state = ST_DONE;
               w_err        = 1'b1;
               w_last_pc    = i_prog_ctr;
            end
         end
         ST_DONE: begin
            if (!i_req) begin
               w_next_state = ST_IDLE;
               w_prog_idx   = (int'(r_prog_idx) >= NUM_PROGS - 1) ? 2'd0 : r_prog_idx + 2'd1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
      w_start = (w_next_state == ST_RUN)  ? START_OFF : START_ON;
      w_done  = (w_next_state == ST_DONE) ? DONE_ON   : DONE_OFF;
   end

   assign o_start      = r_start;
   assign o_done       = r_done;
   assign o_err        = r_err;
   assign o_prog_idx   = r_prog_idx;
   assign o_last_pc    = r_last_pc;
   assign o_entry_addr = entry_lookup(r_prog_idx, NUM_PROGS);

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - scoreboard bench for prog_sequencer
module tb_prog_sequencer;

   localparam int NP = 3;
   localparam int SC = 2;
   localparam int WD = 16;

   logic        clk = 1'b0;
   logic        reset, req, halt;
   logic [10:0] prog_ctr;
   logic        start, done, err;
   logic [10:0] entry_addr, last_pc;
   logic [1:0]  prog_idx;

   always #5 clk = ~clk;

   prog_sequencer #(
      .NUM_PROGS    (NP),
      .START_CYCLES (SC),
      .WDOG_CYCLES  (WD)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_req        (req),
      .i_halt       (halt),
      .i_prog_ctr   (prog_ctr),
      .o_start      (start),
      .o_entry_addr (entry_addr),
      .o_prog_idx   (prog_idx),
      .o_done       (done),
      .o_err        (err),
      .o_last_pc    (last_pc)
   );

   int n_checks = 0;
   int n_errors = 0;
   int exp_idx  = 0;

   typedef struct {
      int          idx;
      logic [10:0] pc;
      logic        err;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] tb_entry(input int idx);
      case (idx)
         1:       return 11'h100;
         2:       return 11'h200;
         default: return 11'h000;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From IDLE: pulse Req, count Start-high cycles until RUN begins
   task automatic launch();
      int n;
      req = 1'b1;
      tick();
      req = 1'b0;
      n = 0;
      while (start && n < 20) begin
         n++;
         tick();
      end
      check("launch_len", n, SC);
      check("run_entry", entry_addr, tb_entry(exp_idx));
      check("run_idx", prog_idx, exp_idx);
   endtask

   // In RUN cycle 1: run for 'cycles' cycles, ending in DONE via Halt or timeout
   task automatic run_body(input int cycles, input bit use_halt, input logic [10:0] end_pc, input bit exp_err);
      exp_t e;
      e.idx = exp_idx;
      e.pc  = end_pc;
      e.err = exp_err;
      sb.push_back(e);
      for (int k = 1; k <= cycles; k++) begin
         prog_ctr = end_pc - 11'(cycles - k);
         halt     = use_halt && (k == cycles);
         req      = (k == 2);
         if (k == cycles) check("run_not_done", done, 1'b0);
         tick();
      end
      halt = 1'b0;
      req  = 1'b1;
      prog_ctr = 11'h7ff;
      check("done_rise", done, 1'b1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("last_pc", last_pc, e.pc);
         check("err", err, e.err);
         check("done_idx", prog_idx, e.idx);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         check("done_hold", done, 1'b1);
      end
      check("done_start", start, 1'b1);
      req = 1'b0;
      tick();
      exp_idx = (exp_idx + 1) % NP;
      check("idle_done", done, 1'b0);
      check("idle_start", start, 1'b1);
      check("idle_idx", prog_idx, exp_idx);
      check("idle_entry", entry_addr, tb_entry(exp_idx));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      exp_idx = 0;
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; halt = 1'b0; prog_ctr = 11'h0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_start", start, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_idx", prog_idx, 0);
      check("rst_last_pc", last_pc, 11'h0);
      check("rst_entry", entry_addr, 11'h0);

      // Halt in IDLE is ignored
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("idle_halt_done", done, 1'b0);

      // Three runs wrap the index 0,1,2,0; first one ends at PC 0x045
      launch();
      run_body(3, 1'b1, 11'h045, 1'b0);
      launch();
      run_body(1, 1'b1, 11'h123, 1'b0);
      launch();
      run_body(6, 1'b1, 11'h3fe, 1'b0);
      check("wrap_idx", prog_idx, 0);
      launch();
      run_body(2, 1'b1, 11'h010, 1'b0);

      // Reset on the 5th RUN cycle
      launch();
      for (int k = 1; k < 5; k++) tick();
      check("run5_start", start, 1'b0);
      do_reset();
      check("mr_start", start, 1'b1);
      check("mr_idx", prog_idx, 0);
      check("mr_done", done, 1'b0);
      check("mr_last_pc", last_pc, 11'h0);

      // Reset mid-LAUNCH, then a normal run still works
      req = 1'b1;
      tick();
      req = 1'b0;
      do_reset();
      tick();
      check("ml_start", start, 1'b1);
      launch();
      run_body(4, 1'b1, 11'h200, 1'b0);

`ifdef SEQ_WATCHDOG_EN
      launch();
      run_body(WD, 1'b0, 11'h0ab, 1'b1);
      launch();
      run_body(WD, 1'b1, 11'h0cd, 1'b0);
`else
      // Without the watchdog only Halt leaves RUN
      launch();
      for (int k = 0; k < 40; k++) tick();
      check("nowd_stay_run", start, 1'b0);
      check("nowd_no_done", done, 1'b0);
      check("nowd_err", err, 1'b0);
      do_reset();
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
